// File: rtl/ram_protocol_monitor.sv
// Protocol monitor for the single-port RAM command interface.
// Taps rx_valid/din/tx_valid/dout and flags command-ordering errors,
// late or spurious read responses and a non-zero dout after reset.
//
// Rules (err_vec bit / err_code value):
//   R0 | wr-addr not followed by wr-data
//   R1 | rd-addr not followed by rd-data
//   R2 | read response (tx_valid) missing within TX_LAT cycles
//   R3 | tx_valid with no read pending
//   R4 | dout non-zero at the first edge after reset release
//
// Sequence FSM states:
//   state   | meaning
//   EXP_ANY | no pending pairing, any command legal
//   EXP_WD  | wr-addr seen, expecting wr-data (01)
//   EXP_RD  | rd-addr seen, expecting rd-data (11)

module ram_protocol_monitor #(
    parameter int DIN_W  = 10,
    parameter int DOUT_W = 8,
    parameter int TX_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [DIN_W-1:0]  din,
    input  logic              tx_valid,
    input  logic [DOUT_W-1:0] dout,
    input  logic              err_clr,
    output logic              err_flag,
    output logic [4:0]        err_vec,
    output logic [2:0]        err_code,
    output logic [CNT_W-1:0]  err_count,
    output logic              rd_pending
);

    typedef enum logic [1:0] {
        EXP_ANY = 2'd0,
        EXP_WD  = 2'd1,
        EXP_RD  = 2'd2
    } seq_state_t;

    localparam logic [1:0] CMD_WA = 2'b00;
    localparam logic [1:0] CMD_WD = 2'b01;
    localparam logic [1:0] CMD_RA = 2'b10;
    localparam logic [1:0] CMD_RD = 2'b11;

    localparam logic [3:0]       TX_LAT_L = 4'(TX_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    seq_state_t       seq_state;
    seq_state_t       seq_next;
    logic [1:0]       cmd;
    logic             rd_accept;
    logic             r0_hit;
    logic             r1_hit;
    logic             r2_hit;
    logic             r3_hit;
    logic             r4_hit;
    logic [4:0]       viol;
    logic             any_viol;
    logic [3:0]       lat_cnt;
    logic [3:0]       lat_cnt_nxt;
    logic             pend_nxt;
    logic             first_cyc;
    logic             din_unused;

    assign cmd        = din[DIN_W-1 -: 2];
    assign rd_accept  = rx_valid && (cmd == CMD_RD);
    assign din_unused = ^din[DIN_W-3:0];

    // Lowest-index rule wins when several fire in the same cycle.
    function automatic logic [2:0] first_rule(input logic [4:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Re-decode of a command as if no pairing were outstanding.
    function automatic seq_state_t decode_any(input logic [1:0] c);
        seq_state_t s;
        case (c)
            CMD_WA:  s = EXP_WD;
            CMD_RA:  s = EXP_RD;
            default: s = EXP_ANY;
        endcase
        return s;
    endfunction

    // Sequence FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seq_state <= EXP_ANY;
        else        seq_state <= seq_next;
    end

    // Sequence FSM next state and ordering violations.
    always_comb begin
        seq_next = seq_state;
        r0_hit   = 1'b0;
        r1_hit   = 1'b0;
        if (rx_valid) begin
            case (seq_state)
                EXP_WD: begin
                    if (cmd == CMD_WD) seq_next = EXP_ANY;
                    else begin
                        r0_hit   = 1'b1;
                        seq_next = decode_any(cmd);
                    end
                end
                EXP_RD: begin
                    if (cmd == CMD_RD) seq_next = EXP_ANY;
                    else begin
                        r1_hit   = 1'b1;
                        seq_next = decode_any(cmd);
                    end
                end
                default: seq_next = decode_any(cmd);
            endcase
        end
    end

    // Read-response tracker: down-counter, timeout when the count would hit zero.
    always_comb begin
        pend_nxt    = rd_pending;
        lat_cnt_nxt = lat_cnt;
        r2_hit      = 1'b0;
        r3_hit      = 1'b0;
        if (rd_pending) begin
            if (tx_valid) begin
                pend_nxt    = 1'b0;
                lat_cnt_nxt = 4'd0;
            end else if (lat_cnt <= 4'd1) begin
                pend_nxt    = 1'b0;
                lat_cnt_nxt = 4'd0;
                r2_hit      = 1'b1;
            end else begin
                lat_cnt_nxt = lat_cnt - 4'd1;
            end
        end else if (tx_valid) begin
            r3_hit = 1'b1;
        end
        // A new read while the old one is still unanswered abandons the old one.
        if (rd_accept) begin
            if (rd_pending && !tx_valid) r2_hit = 1'b1;
            pend_nxt    = 1'b1;
            lat_cnt_nxt = TX_LAT_L;
        end
    end

    // Tracker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            lat_cnt    <= 4'd0;
        end else begin
            rd_pending <= pend_nxt;
            lat_cnt    <= lat_cnt_nxt;
        end
    end

    // First edge after reset release checks that the RAM output is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) first_cyc <= 1'b1;
        else        first_cyc <= 1'b0;
    end

    assign r4_hit   = first_cyc && (dout != '0);
    assign viol     = {r4_hit, r3_hit, r2_hit, r1_hit, r0_hit};
    assign any_viol = |viol;

    // Sticky error state; a violation in a clear cycle becomes the new first error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vec   <= 5'd0;
            err_code  <= 3'd0;
            err_count <= '0;
        end else if (err_clr) begin
            err_vec   <= viol;
            err_code  <= any_viol ? first_rule(viol) : 3'd0;
            err_count <= any_viol ? CNT_W'(1) : '0;
        end else begin
            err_vec <= err_vec | viol;
            if (any_viol && (err_vec == 5'd0)) err_code <= first_rule(viol);
            if (any_viol && (err_count != CNT_MAX)) err_count <= err_count + CNT_W'(1);
        end
    end

    assign err_flag = |err_vec;

endmodule

// File: tb/tb_ram_protocol_monitor.sv
// Directed bench for ram_protocol_monitor. Two instances share stimulus:
// dut_a uses default parameters (TX_LAT=1, CNT_W=8),
// dut_b uses TX_LAT=3, CNT_W=2 for latency and saturation boundaries.

module tb_ram_protocol_monitor;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [9:0] din;
    logic       tx_valid;
    logic [7:0] dout;
    logic       err_clr;

    logic       a_flag;
    logic [4:0] a_vec;
    logic [2:0] a_code;
    logic [7:0] a_count;
    logic       a_pend;

    logic       b_flag;
    logic [4:0] b_vec;
    logic [2:0] b_code;
    logic [1:0] b_count;
    logic       b_pend;

    int n_checks;
    int n_errors;

    ram_protocol_monitor dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .din        (din),
        .tx_valid   (tx_valid),
        .dout       (dout),
        .err_clr    (err_clr),
        .err_flag   (a_flag),
        .err_vec    (a_vec),
        .err_code   (a_code),
        .err_count  (a_count),
        .rd_pending (a_pend)
    );

    ram_protocol_monitor #(
        .DIN_W  (10),
        .DOUT_W (8),
        .TX_LAT (3),
        .CNT_W  (2)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .din        (din),
        .tx_valid   (tx_valid),
        .dout       (dout),
        .err_clr    (err_clr),
        .err_flag   (b_flag),
        .err_vec    (b_vec),
        .err_code   (b_code),
        .err_count  (b_count),
        .rd_pending (b_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs after a falling edge, sample at the next falling edge.
    task automatic cyc(input logic rv, input logic [1:0] c, input logic tv, input logic clr);
        rx_valid = rv;
        din      = {c, 8'h3C};
        tx_valid = tv;
        err_clr  = clr;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        tx_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic clr_all();
        cyc(1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        tx_valid = 1'b0;
        dout     = 8'h00;
        err_clr  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_vec",   32'(a_vec),   32'h0);
        chk("rst_count", 32'(a_count), 32'h0);
        chk("rst_flag",  32'(a_flag),  32'h0);
        chk("rst_pend",  32'(b_pend),  32'h0);
        rst_n = 1'b1;

        // T1: clean write and read sequence, response one cycle after rd-data.
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 2'b01, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        chk("t1_pend_set", 32'(a_pend), 32'h1);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("t1_pend_clr", 32'(a_pend),  32'h0);
        chk("t1_a_vec",    32'(a_vec),   32'h0);
        chk("t1_a_count",  32'(a_count), 32'h0);
        chk("t1_b_vec",    32'(b_vec),   32'h0);

        // T2: wr-addr followed by rd-addr -> R0, FSM re-decodes into EXP_RD.
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 1'b0, 1'b0);
        chk("t2_vec",   32'(a_vec),   32'h01);
        chk("t2_code",  32'(a_code),  32'h0);
        chk("t2_count", 32'(a_count), 32'h1);
        chk("t2_flag",  32'(a_flag),  32'h1);
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("t2_vec_hold",   32'(a_vec),   32'h01);
        chk("t2_count_hold", 32'(a_count), 32'h1);
        clr_all();
        chk("t2_clr_vec", 32'(a_vec), 32'h0);

        // R1: rd-addr followed by wr-addr.
        cyc(1'b1, 2'b10, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        chk("r1_vec",  32'(a_vec),  32'h02);
        chk("r1_code", 32'(a_code), 32'h1);
        cyc(1'b1, 2'b01, 1'b0, 1'b0);
        chk("r1_wd_ok", 32'(a_count), 32'h1);
        clr_all();

        // T3: no response; dut_a (TX_LAT=1) times out after one edge, dut_b after three.
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        idle(1);
        chk("t3_a_vec",  32'(a_vec),  32'h04);
        chk("t3_a_pend", 32'(a_pend), 32'h0);
        chk("t3_b_pend1", 32'(b_pend), 32'h1);
        idle(1);
        chk("t3_b_vec2",  32'(b_vec),  32'h00);
        chk("t3_b_pend2", 32'(b_pend), 32'h1);
        idle(1);
        chk("t3_b_vec3",  32'(b_vec),  32'h04);
        chk("t3_b_code",  32'(b_code), 32'h2);
        chk("t3_b_pend3", 32'(b_pend), 32'h0);
        clr_all();

        // dut_b: response on the last legal edge is accepted.
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("t3_b_lastok", 32'(b_vec),  32'h00);
        chk("t3_b_pendok", 32'(b_pend), 32'h0);
        clr_all();

        // T4: spurious tx_valid, then tx_valid held two cycles after a read.
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("t4_vec1",  32'(a_vec),  32'h08);
        chk("t4_code",  32'(a_code), 32'h3);
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("t4_a_count", 32'(a_count), 32'h2);
        chk("t4_b_count", 32'(b_count), 32'h2);
        chk("t4_b_vec",   32'(b_vec),   32'h08);
        clr_all();

        // Back-to-back rd-data: old read abandoned (R2), tracker reloads.
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        chk("b2b_b_vec",  32'(b_vec),  32'h04);
        chk("b2b_b_pend", 32'(b_pend), 32'h1);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("b2b_b_count", 32'(b_count), 32'h1);
        chk("b2b_b_pend2", 32'(b_pend),  32'h0);
        clr_all();

        // T5: dout non-zero at reset release -> R4.
        @(negedge clk);
        rst_n = 1'b0;
        dout  = 8'h5A;
        #2;
        chk("t5_rst_vec", 32'(a_vec), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        dout = 8'h00;
        chk("t5_vec",  32'(a_vec),  32'h10);
        chk("t5_code", 32'(a_code), 32'h4);
        idle(1);
        chk("t5_once", 32'(a_count), 32'h1);
        clr_all();
        chk("t5_clr_vec",   32'(a_vec),   32'h0);
        chk("t5_clr_code",  32'(a_code),  32'h0);
        chk("t5_clr_count", 32'(a_count), 32'h0);
        chk("t5_clr_flag",  32'(a_flag),  32'h0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 1'b0, 1'b1);
        chk("t5_win_vec",   32'(a_vec),   32'h01);
        chk("t5_win_code",  32'(a_code),  32'h0);
        chk("t5_win_count", 32'(a_count), 32'h1);
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        clr_all();

        // T6: dut_b counter saturates at 3.
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("t6_count3", 32'(b_count), 32'h3);
        for (int i = 0; i < 2; i++) cyc(1'b0, 2'b00, 1'b1, 1'b0);
        chk("t6_count5", 32'(b_count), 32'h3);
        chk("t6_a_count5", 32'(a_count), 32'h5);
        clr_all();

        // T6: reset pulse mid-read drops the pending read without R2 later.
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        chk("t6_pend_pre", 32'(b_pend), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("t6_pend_rst", 32'(b_pend), 32'h0);
        rst_n = 1'b1;
        idle(5);
        chk("t6_b_vec_post", 32'(b_vec), 32'h0);
        chk("t6_a_vec_post", 32'(a_vec), 32'h0);
        chk("t6_b_pend_post", 32'(b_pend), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
